alarm_bank: RTL



---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_channel.sv | 132 +++++++++++++
 rtl/alarm_bank.sv | 85 ++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types, widths and time-of-day helpers for the alarm bank.
package alarm_pkg;

  localparam int MIN_W            = 6;
  localparam int HR_W             = 4;
  localparam int MINUTES_PER_HOUR = 60;
  localparam int HOURS_PER_CYCLE  = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  // 12-hour dial step: 12 -> 1, 11 -> 12.
  function automatic logic [HR_W-1:0] next_hour(input logic [HR_W-1:0] h);
    return HR_W'((int'(h) % HOURS_PER_CYCLE) + 1);
  endfunction

  // Minute step with wrap; never carries into the hour.
  function automatic logic [MIN_W-1:0] next_minute(input logic [MIN_W-1:0] m);
    return MIN_W'((int'(m) + 1) % MINUTES_PER_HOUR);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: set time, arming, ring/snooze FSM, snooze wake time,
// snooze budget and ring timeout.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [MIN_W-1:0] clock_minutes,
  input  logic [HR_W-1:0]  clock_hours,
  input  logic             en,
  input  logic             inc_minute,
  input  logic             inc_hour,
  input  logic             snooze,
  input  logic             dismiss,
  output logic [MIN_W-1:0] set_minutes,
  output logic [HR_W-1:0]  set_hours,
  output logic             ringing,
  output logic             snoozed
);

  localparam int CNT_W  = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam int RING_W = 8;

  alarm_state_e      state, state_nxt;
  logic              armed;
  logic [CNT_W-1:0]  snooze_cnt;
  logic [RING_W-1:0] ring_cnt;
  logic [MIN_W-1:0]  wake_minutes, snooze_minutes;
  logic [HR_W-1:0]   wake_hours, snooze_hours;
  logic [MIN_W:0]    snooze_sum;
  logic              snooze_wrap;
  logic              at_set, at_wake, snooze_ok, timeout;
  logic              leaving, entering_ring, taking_snooze;

  assign at_set    = (clock_minutes == set_minutes) && (clock_hours == set_hours);
  assign at_wake   = (clock_minutes == wake_minutes) && (clock_hours == wake_hours);
  assign snooze_ok = snooze && (snooze_cnt < CNT_W'(MAX_SNOOZE));
  assign timeout   = tick && (ring_cnt == RING_W'(RING_TIMEOUT_S - 1));

  // Wake time = now + SNOOZE_MIN; a minute wrap advances the 12-hour dial.
  assign snooze_sum     = {1'b0, clock_minutes} + (MIN_W+1)'(SNOOZE_MIN);
  assign snooze_wrap    = snooze_sum >= (MIN_W+1)'(MINUTES_PER_HOUR);
  assign snooze_minutes = MIN_W'(snooze_wrap ? snooze_sum - (MIN_W+1)'(MINUTES_PER_HOUR)
                                             : snooze_sum);
  assign snooze_hours   = snooze_wrap ? next_hour(clock_hours) : clock_hours;

  assign leaving       = (state != IDLE) && (state_nxt != state);
  assign entering_ring = (state_nxt == RINGING) && (state != RINGING);
  assign taking_snooze = (state == RINGING) && (state_nxt == SNOOZED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: disable > dismiss > snooze > timeout > wake/match.
  always_comb begin
    // NOTE: default first so no path through the block leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (armed && at_set) state_nxt = RINGING;
        RINGING: begin
          if (dismiss)        state_nxt = IDLE;
          else if (snooze_ok) state_nxt = SNOOZED;
          else if (timeout)   state_nxt = IDLE;
        end
        SNOOZED: begin
          if (dismiss)      state_nxt = IDLE;
          else if (at_wake) state_nxt = RINGING;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    ringing = (state == RINGING);
    snoozed = (state == SNOOZED);
  end

  // Arming, snooze budget, ring counter and latched wake time.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every control register is reset so that a reset in mid-episode
    // leaves no stale counts or wake time behind.
    if (rst) begin
      armed        <= 1'b0;
      snooze_cnt   <= '0;
      ring_cnt     <= '0;
      wake_minutes <= '0;
      wake_hours   <= HR_W'(HOURS_PER_CYCLE);
    end else begin
      if (leaving)      armed <= 1'b0;
      else if (!at_set) armed <= 1'b1;

      if (state_nxt == IDLE) snooze_cnt <= '0;
      else if (taking_snooze) snooze_cnt <= snooze_cnt + CNT_W'(1);

      if (entering_ring) ring_cnt <= '0;
      else if ((state == RINGING) && tick) ring_cnt <= ring_cnt + RING_W'(1);

      if (taking_snooze) begin
        wake_minutes <= snooze_minutes;
        wake_hours   <= snooze_hours;
      end
    end
  end

  // Set-time edits; accepted in any state, minute never carries into hour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_minutes <= '0;
      set_hours   <= HR_W'(HOURS_PER_CYCLE);
    end else begin
      if (inc_minute) set_minutes <= next_minute(set_minutes);
      if (inc_hour)   set_hours   <= next_hour(set_hours);
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS alarm channels with edit decode, readback mux and a
// registered any-ringing flag.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int SEL_W          = 2,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                  clk_pi,
  input  logic                  rst_pi,
  input  logic                  tick_pi,
  input  logic [MIN_W-1:0]      clock_minutes_pi,
  input  logic [HR_W-1:0]       clock_hours_pi,
  input  logic [NUM_ALARMS-1:0] alarm_en_pi,
  input  logic [SEL_W-1:0]      sel_pi,
  input  logic                  inc_minute_pi,
  input  logic                  inc_hour_pi,
  input  logic                  snooze_pi,
  input  logic                  dismiss_pi,
  output logic [MIN_W-1:0]      sel_minutes_po,
  output logic [HR_W-1:0]       sel_hours_po,
  output logic [NUM_ALARMS-1:0] ringing_po,
  output logic [NUM_ALARMS-1:0] snoozed_po,
  output logic                  any_ringing_po
);

  logic [NUM_ALARMS-1:0] edit_minute, edit_hour;
  logic [MIN_W-1:0]      set_minutes [NUM_ALARMS];
  logic [HR_W-1:0]       set_hours   [NUM_ALARMS];

  // Route edit pulses to the selected channel; out-of-range selects hit nothing.
  always_comb begin
    edit_minute = '0;
    edit_hour   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      edit_minute[i] = inc_minute_pi && (sel_pi == SEL_W'(i));
      edit_hour[i]   = inc_hour_pi   && (sel_pi == SEL_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN    (SNOOZE_MIN),
      .MAX_SNOOZE    (MAX_SNOOZE),
      .RING_TIMEOUT_S(RING_TIMEOUT_S)
    ) u_ch (
      .clk          (clk_pi),
      .rst          (rst_pi),
      .tick         (tick_pi),
      .clock_minutes(clock_minutes_pi),
      .clock_hours  (clock_hours_pi),
      .en           (alarm_en_pi[i]),
      .inc_minute   (edit_minute[i]),
      .inc_hour     (edit_hour[i]),
      .snooze       (snooze_pi),
      .dismiss      (dismiss_pi),
      .set_minutes  (set_minutes[i]),
      .set_hours    (set_hours[i]),
      .ringing      (ringing_po[i]),
      .snoozed      (snoozed_po[i])
    );
  end

  // Readback of the selected channel's set time; zero when sel is out of range.
  always_comb begin
    sel_minutes_po = '0;
    sel_hours_po   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_pi == SEL_W'(i)) begin
        sel_minutes_po = set_minutes[i];
        sel_hours_po   = set_hours[i];
      end
    end
  end

  // Registered summary of all ringing channels for the shared buzzer/LED.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) any_ringing_po <= 1'b0;
    else        any_ringing_po <= |ringing_po;
  end

endmodule
